// File: rtl/pwm_pkg.sv
// pwm_pkg: shared definitions for the multi-channel PWM block.
//   - register addresses and CTL0 bit positions
//   - counter direction type
//   - LFSR tap mask, dither shift decode and 8-bit rotate helper
package pwm_pkg;

    localparam logic [7:0] ADDR_CTL0      = 8'h00;
    localparam logic [7:0] ADDR_STATUS    = 8'h01;
    localparam logic [7:0] ADDR_POL       = 8'h02;
    localparam logic [7:0] ADDR_CHEN      = 8'h03;
    localparam logic [7:0] ADDR_DUTY_BASE = 8'h10;

    localparam int CTL0_EN     = 7;
    localparam int CTL0_CENTER = 6;
    localparam int CTL0_IRQ_EN = 5;

    // Implemented CTL0 bits: EN, CENTER, IRQ_EN, SS[1:0]
    localparam logic [7:0] CTL0_MASK = 8'hE3;

    localparam logic [7:0] LFSR_TAPS = 8'h1D;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Larger SS selects a smaller shift, i.e. a larger dither amplitude.
    function automatic logic [2:0] ss_shift(input logic [1:0] ss);
        logic [2:0] sh;
        case (ss)
            2'b11:   sh = 3'd1;
            2'b10:   sh = 3'd3;
            2'b01:   sh = 3'd5;
            default: sh = 3'd0;
        endcase
        return sh;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int unsigned n);
        logic [15:0] dbl;
        dbl = {v, v} << (n % 8);
        return dbl[15:8];
    endfunction

endpackage

// File: rtl/pwm_lfsr.sv
// pwm_lfsr: 8-bit Galois LFSR used as the dither source.
//   clk_i   clock
//   nrst_i  asynchronous active-low reset, loads SEED
//   step_i  advance one step this cycle
//   lfsr_o  current register value
module pwm_lfsr
    import pwm_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hFF
) (
    input  logic       clk_i,
    input  logic       nrst_i,
    input  logic       step_i,
    output logic [7:0] lfsr_o
);

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            lfsr_o <= SEED;
        end else if (step_i) begin
            lfsr_o <= {lfsr_o[6:0], 1'b0} ^ (lfsr_o[7] ? LFSR_TAPS : 8'h00);
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: NUM_CH PWM outputs sharing one PWM_BITS counter, with
// double-buffered duty, polarity/enable per channel, optional
// center-aligned counting, LFSR dither and a period-complete flag.
//   clk_i      clock
//   nrst_i     asynchronous active-low reset
//   b_addr_i   register address
//   b_data_i   register write data
//   b_write_i  write strobe
//   b_data_o   combinational read data
//   pwm_o      registered PWM outputs
//   irq_o      registered interrupt (PF & IRQ_EN)
//
// Count direction (center mode only; edge mode always counts up)
//   state    | meaning
//   DIR_UP   | counting 0 -> MAX
//   DIR_DOWN | counting MAX-1 -> 1, then back to 0 / DIR_UP
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int         NUM_CH    = 4,
    parameter int         PWM_BITS  = 10,
    parameter logic [7:0] LFSR_SEED = 8'hFF
) (
    input  logic              clk_i,
    input  logic              nrst_i,
    input  logic [7:0]        b_addr_i,
    input  logic [7:0]        b_data_i,
    input  logic              b_write_i,
    output logic [7:0]        b_data_o,
    output logic [NUM_CH-1:0] pwm_o,
    output logic              irq_o
);

    localparam logic [PWM_BITS-1:0] MAX  = '1;
    localparam logic [PWM_BITS-1:0] ONE  = {{(PWM_BITS-1){1'b0}}, 1'b1};
    localparam logic [PWM_BITS:0]   FULL = {1'b1, {PWM_BITS{1'b0}}};

    logic [7:0]          ctl0_q;
    logic                pf_q;
    logic [NUM_CH-1:0]   pol_q;
    logic [NUM_CH-1:0]   chen_q;
    logic [PWM_BITS-1:0] duty_pend_q [NUM_CH];
    logic [PWM_BITS-1:0] duty_act_q  [NUM_CH];
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    dir_e                dir_q, dir_d;
    logic [7:0]          lfsr;

    logic       en, center;
    logic [1:0] ss;
    logic [2:0] shift;
    logic       be;

    assign en     = ctl0_q[CTL0_EN];
    assign center = ctl0_q[CTL0_CENTER];
    assign ss     = ctl0_q[1:0];
    assign shift  = ss_shift(ss);

    // ---------------- bus decode ----------------
    logic       wr_ctl0, wr_status, wr_pol, wr_chen;
    logic [7:0] duty_off;
    logic       duty_hit;
    logic [2:0] duty_ch;
    logic       duty_lo;
    logic [7:0] ctl0_d;
    logic       pf_d;

    assign wr_ctl0   = b_write_i && (b_addr_i == ADDR_CTL0);
    assign wr_status = b_write_i && (b_addr_i == ADDR_STATUS);
    assign wr_pol    = b_write_i && (b_addr_i == ADDR_POL);
    assign wr_chen   = b_write_i && (b_addr_i == ADDR_CHEN);

    assign duty_off = b_addr_i - ADDR_DUTY_BASE;
    assign duty_hit = (b_addr_i >= ADDR_DUTY_BASE) && (duty_off < 8'(2 * NUM_CH));
    assign duty_ch  = duty_off[3:1];
    assign duty_lo  = duty_off[0];

    assign ctl0_d = wr_ctl0 ? (b_data_i & CTL0_MASK) : ctl0_q;
    // A boundary event beats a same-cycle clear so no period is lost.
    assign pf_d   = be ? 1'b1 : ((wr_status && b_data_i[0]) ? 1'b0 : pf_q);

    // ---------------- counter ----------------
    always_comb begin
        cnt_d = '0;
        dir_d = DIR_UP;
        if (en) begin
            if (!center) begin
                cnt_d = cnt_q + ONE;
            end else if (dir_q == DIR_UP) begin
                if (cnt_q == MAX) begin
                    cnt_d = MAX - ONE;
                    dir_d = DIR_DOWN;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end else begin
                if (cnt_q <= ONE) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q - ONE;
                    dir_d = DIR_DOWN;
                end
            end
        end
    end

    assign be = en && (cnt_d == '0);

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            cnt_q <= '0;
            dir_q <= DIR_UP;
        end else begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
        end
    end

    // ---------------- dither source ----------------
    pwm_lfsr #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk_i (clk_i),
        .nrst_i(nrst_i),
        .step_i(be && (ss != 2'b00)),
        .lfsr_o(lfsr)
    );

    // ---------------- per-channel compare ----------------
    logic [NUM_CH-1:0] raw;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [7:0]        rot;
        logic [7:0]        dith;
        logic [PWM_BITS:0] sum;
        logic [PWM_BITS:0] eff;

        assign rot  = rotl8(lfsr, c);
        assign dith = (en && (ss != 2'b00)) ? (rot >> shift) : 8'h00;
        assign sum  = {1'b0, duty_act_q[c]} + {{(PWM_BITS-7){1'b0}}, dith};
        assign eff  = (sum > FULL) ? FULL : sum;
        assign raw[c] = {1'b0, cnt_q} < eff;
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            ctl0_q <= '0;
            pf_q   <= 1'b0;
            pol_q  <= '0;
            chen_q <= '0;
            pwm_o  <= '0;
            irq_o  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                duty_pend_q[c] <= '0;
                duty_act_q[c]  <= '0;
            end
        end else begin
            ctl0_q <= ctl0_d;
            pf_q   <= pf_d;
            irq_o  <= pf_d && ctl0_d[CTL0_IRQ_EN];
            if (wr_pol) begin
                pol_q <= b_data_i[NUM_CH-1:0];
            end
            if (wr_chen) begin
                chen_q <= b_data_i[NUM_CH-1:0];
            end
            // Disabled channels and EN=0 both fall back to the idle polarity.
            pwm_o <= pol_q ^ (raw & chen_q & {NUM_CH{en}});
            for (int c = 0; c < NUM_CH; c++) begin
                // Active duty samples the pending value before this cycle's write.
                if (!en || be) begin
                    duty_act_q[c] <= duty_pend_q[c];
                end
                if (b_write_i && duty_hit && (duty_ch == 3'(c))) begin
                    if (duty_lo) begin
                        duty_pend_q[c][7:0] <= b_data_i;
                    end else begin
                        duty_pend_q[c][PWM_BITS-1:8] <= b_data_i[PWM_BITS-9:0];
                    end
                end
            end
        end
    end

    // ---------------- read mux ----------------
    always_comb begin
        b_data_o = '0;
        case (b_addr_i)
            ADDR_CTL0:   b_data_o = ctl0_q;
            ADDR_STATUS: b_data_o = {7'd0, pf_q};
            ADDR_POL:    b_data_o[NUM_CH-1:0] = pol_q;
            ADDR_CHEN:   b_data_o[NUM_CH-1:0] = chen_q;
            default: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (duty_hit && (duty_ch == 3'(c))) begin
                        b_data_o = duty_lo ? duty_pend_q[c][7:0]
                                           : 8'(duty_pend_q[c][PWM_BITS-1:8]);
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed self-checking bench for pwm_multi
// (NUM_CH=4, PWM_BITS=10, LFSR_SEED=0xFF).
module tb_pwm_multi;

    localparam int NUM_CH   = 4;
    localparam int PWM_BITS = 10;

    logic              clk_i     = 1'b0;
    logic              nrst_i    = 1'b1;
    logic [7:0]        b_addr_i  = 8'h00;
    logic [7:0]        b_data_i  = 8'h00;
    logic              b_write_i = 1'b0;
    logic [7:0]        b_data_o;
    logic [NUM_CH-1:0] pwm_o;
    logic              irq_o;

    int n_cmp = 0;
    int n_err = 0;

    pwm_multi #(
        .NUM_CH   (NUM_CH),
        .PWM_BITS (PWM_BITS),
        .LFSR_SEED(8'hFF)
    ) dut (
        .clk_i    (clk_i),
        .nrst_i   (nrst_i),
        .b_addr_i (b_addr_i),
        .b_data_i (b_data_i),
        .b_write_i(b_write_i),
        .b_data_o (b_data_o),
        .pwm_o    (pwm_o),
        .irq_o    (irq_o)
    );

    always #5 clk_i = ~clk_i;

    // Run-length monitor on one selectable channel, sampled on the falling edge.
    int   mon_ch      = 0;
    logic mon_prev    = 1'b0;
    int   mon_run     = 0;
    int   mon_cyc     = 0;
    int   mon_rise_at = 0;
    int   last_hi     = 0;
    int   last_lo     = 0;
    int   last_period = 0;

    always @(negedge clk_i) begin
        mon_cyc++;
        if (pwm_o[mon_ch] === mon_prev) begin
            mon_run++;
        end else begin
            if (mon_prev === 1'b1) begin
                last_hi = mon_run;
            end else begin
                last_lo     = mon_run;
                last_period = mon_cyc - mon_rise_at;
                mon_rise_at = mon_cyc;
            end
            mon_run  = 1;
            mon_prev = pwm_o[mon_ch];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk_i);
        b_addr_i  = a;
        b_data_i  = d;
        b_write_i = 1'b1;
        @(negedge clk_i);
        b_write_i = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
        @(negedge clk_i);
        b_addr_i = a;
        #1;
        chk(tag, b_data_o, exp);
    endtask

    // Waits for a rising (rising=1) or falling edge on the monitored channel.
    task automatic wait_edge(input string tag, input logic rising);
        logic prev;
        bit   seen;
        prev = pwm_o[mon_ch];
        seen = 1'b0;
        for (int i = 0; i < 4500 && !seen; i++) begin
            @(negedge clk_i);
            if (prev !== rising && pwm_o[mon_ch] === rising) seen = 1'b1;
            prev = pwm_o[mon_ch];
        end
        #1;
        n_cmp++;
        assert (seen) else begin
            n_err++;
            $error("FAIL %s: observed no edge expected edge within 4500 cycles", tag);
        end
    endtask

    int c0, c1, c2;

    initial begin
        // ---------------- reset state ----------------
        #1 nrst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_pwm", pwm_o, 4'h0);
        chk("rst_irq", irq_o, 1'b0);
        nrst_i = 1'b1;
        rd("rst_ctl0", 8'h00, 8'h00);
        rd("rst_status", 8'h01, 8'h00);
        rd("rst_duty0_hi", 8'h10, 8'h00);

        // ---------------- register access ----------------
        wr(8'h00, 8'h1C);
        rd("ctl0_unimpl_bits", 8'h00, 8'h00);
        wr(8'h10, 8'hFF);
        rd("duty_hi_width", 8'h10, 8'h03);
        wr(8'h11, 8'h5A);
        rd("duty_lo", 8'h11, 8'h5A);
        wr(8'h18, 8'hFF);
        rd("unmapped_ch4", 8'h18, 8'h00);
        wr(8'h02, 8'hFF);
        rd("pol_width", 8'h02, 8'h0F);
        wr(8'h02, 8'h00);

        // ---------------- edge mode ----------------
        wr(8'h10, 8'h01);
        wr(8'h11, 8'h00);
        wr(8'h15, 8'hFF);
        wr(8'h14, 8'h03);
        wr(8'h03, 8'h0F);
        mon_ch = 0;
        wr(8'h00, 8'h80);
        wait_edge("edge_rise0", 1'b1);
        wait_edge("edge_fall0", 1'b0);
        chk("edge_ch0_high", last_hi, 256);
        wait_edge("edge_rise1", 1'b1);
        chk("edge_ch0_low", last_lo, 768);
        chk("edge_period", last_period, 1024);
        c1 = 0;
        c2 = 0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk_i);
            c1 += int'(pwm_o[1]);
            c2 += int'(pwm_o[2]);
        end
        chk("edge_ch1_zero", c1, 0);
        chk("edge_ch2_max", c2, 1023);

        // ---------------- shadow update ----------------
        wait_edge("shadow_rise", 1'b1);
        repeat (50) @(negedge clk_i);
        wr(8'h10, 8'h02);
        wait_edge("shadow_fall0", 1'b0);
        chk("shadow_current", last_hi, 256);
        wait_edge("shadow_fall1", 1'b0);
        chk("shadow_next", last_hi, 512);

        // Write landing exactly on the boundary edge (1023 cycles after the rise).
        wait_edge("be_rise", 1'b1);
        repeat (1021) @(negedge clk_i);
        wr(8'h10, 8'h01);
        wait_edge("be_fall0", 1'b0);
        chk("be_write_deferred", last_hi, 512);
        wait_edge("be_fall1", 1'b0);
        chk("be_write_applied", last_hi, 256);

        // ---------------- center mode ----------------
        wr(8'h00, 8'h00);
        wr(8'h00, 8'hC0);
        wait_edge("ctr_rise0", 1'b1);
        wait_edge("ctr_fall0", 1'b0);
        chk("ctr_first_high", last_hi, 256);
        wait_edge("ctr_rise1", 1'b1);
        wait_edge("ctr_fall1", 1'b0);
        chk("ctr_high", last_hi, 511);
        wait_edge("ctr_rise2", 1'b1);
        chk("ctr_period", last_period, 2046);
        chk("ctr_low", last_lo, 1535);

        // ---------------- polarity / enable ----------------
        wr(8'h00, 8'h00);
        wr(8'h02, 8'h01);
        wr(8'h00, 8'h80);
        wait_edge("pol_fall0", 1'b0);
        wait_edge("pol_rise", 1'b1);
        chk("pol_low", last_lo, 256);
        wait_edge("pol_fall1", 1'b0);
        chk("pol_high", last_hi, 768);
        wr(8'h03, 8'h0E);
        c0 = 0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk_i);
            c0 += int'(pwm_o[0]);
        end
        chk("chen_off_held", c0, 1100);
        wr(8'h02, 8'h05);
        wr(8'h00, 8'h00);
        @(negedge clk_i);
        chk("en0_pwm_is_pol", pwm_o, 4'h5);

        // ---------------- dither / status ----------------
        wr(8'h01, 8'h01);
        rd("pf_cleared", 8'h01, 8'h00);
        wr(8'h02, 8'h00);
        wr(8'h03, 8'h0F);
        wr(8'h10, 8'h03);
        wr(8'h11, 8'hFF);
        mon_ch = 1;
        wr(8'h00, 8'hA3);
        wait_edge("dith_rise0", 1'b1);
        b_addr_i = 8'h01;
        #1;
        chk("dith_pf_before_be", b_data_o, 8'h00);
        chk("dith_irq_before_be", irq_o, 1'b0);
        wait_edge("dith_fall0", 1'b0);
        chk("dith_lfsr_ff", last_hi, 127);
        wait_edge("dith_rise1", 1'b1);
        b_addr_i = 8'h01;
        #1;
        chk("pf_after_be", b_data_o, 8'h01);
        chk("irq_after_be", irq_o, 1'b1);
        wait_edge("dith_fall1", 1'b0);
        chk("dith_lfsr_e3", last_hi, 99);
        wait_edge("dith_fall2", 1'b0);
        chk("dith_lfsr_db", last_hi, 91);
        c0 = 0;
        for (int i = 0; i < 2048; i++) begin
            @(negedge clk_i);
            c0 += int'(pwm_o[0]);
        end
        chk("dith_saturated", c0, 2048);

        wait_edge("w1c_rise0", 1'b1);
        wr(8'h01, 8'h01);
        b_addr_i = 8'h01;
        #1;
        chk("w1c_clears_pf", b_data_o, 8'h00);
        chk("w1c_clears_irq", irq_o, 1'b0);
        wait_edge("w1c_rise1", 1'b1);
        repeat (1021) @(negedge clk_i);
        wr(8'h01, 8'h01);
        b_addr_i = 8'h01;
        #1;
        chk("w1c_on_be_set_wins", b_data_o, 8'h01);
        chk("w1c_on_be_irq", irq_o, 1'b1);

        // ---------------- mid-run reset ----------------
        repeat (300) @(negedge clk_i);
        nrst_i = 1'b0;
        #1;
        chk("mid_rst_pwm", pwm_o, 4'h0);
        chk("mid_rst_irq", irq_o, 1'b0);
        rd("mid_rst_ctl0", 8'h00, 8'h00);
        rd("mid_rst_status", 8'h01, 8'h00);
        rd("mid_rst_pol", 8'h02, 8'h00);
        rd("mid_rst_chen", 8'h03, 8'h00);
        rd("mid_rst_duty0_hi", 8'h10, 8'h00);
        rd("mid_rst_duty0_lo", 8'h11, 8'h00);
        @(negedge clk_i);
        nrst_i = 1'b1;
        wr(8'h03, 8'h02);
        wr(8'h00, 8'h83);
        wait_edge("post_rst_rise0", 1'b1);
        wait_edge("post_rst_fall", 1'b0);
        chk("post_rst_lfsr_seed", last_hi, 127);
        wait_edge("post_rst_rise1", 1'b1);
        chk("post_rst_period", last_period, 1024);
        b_addr_i = 8'h01;
        #1;
        chk("post_rst_pf", b_data_o, 8'h01);
        chk("post_rst_irq_masked", irq_o, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
